// File: rtl/fft_frame_scheduler.sv
// Round-robin scheduler sharing one radix-2 FFT between NUM_ANT antenna streams.
// Each complex_product_t sample travels as a packed {re, im} word of 2*DATA_W bits.
module fft_frame_scheduler #(
  parameter int N            = 8,
  parameter int NUM_ANT      = 2,
  parameter int MAX_INFLIGHT = 2,
  parameter int DATA_W       = 16,
  localparam int CW = 2 * DATA_W,
  localparam int AW = $clog2(NUM_ANT),
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_ANT-1:0]           req_i,
  input  logic [NUM_ANT-1:0]           in_valid_i,
  input  logic [NUM_ANT-1:0][CW-1:0]   in_data_0_i,
  input  logic [NUM_ANT-1:0][CW-1:0]   in_data_1_i,
  output logic [NUM_ANT-1:0]           grant_o,
  output logic                         fft_enable_o,
  output logic [CW-1:0]                fft_data_in_0_o,
  output logic [CW-1:0]                fft_data_in_1_o,
  input  logic                         fft_out_valid_i,
  output logic                         out_valid_o,
  output logic [AW-1:0]                out_ant_id_o,
  output logic [IW-1:0]                inflight_o,
  output logic                         underrun_err_o,
  output logic                         tag_err_o
);

  localparam int HALF = N / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [AW-1:0]       last_q, last_d;
  logic [NUM_ANT-1:0]  grant_q, grant_d;

  logic                vld_p1_q;
  logic [CW-1:0]       dat0_p1_q, dat1_p1_q;
  logic [CW-1:0]       dat0_d, dat1_d;

  logic [AW-1:0]       tag_mem_q [MAX_INFLIGHT];
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [IW-1:0]       cnt_q, cnt_after_pop;
  logic                under_q, tagerr_q;

  logic                stream, last_beat, pop, push, arb_ok, start, win_found;
  logic [AW-1:0]       winner, cand;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration sees the occupancy left after a same-cycle pop.
  always_comb begin
    pop           = fft_out_valid_i && (cnt_q != '0);
    cnt_after_pop = cnt_q - IW'(pop);
    arb_ok        = (|req_i) && (cnt_after_pop < IW'(MAX_INFLIGHT));
    stream        = (state_q == STREAM);
    last_beat     = (beat_q == BW'(HALF - 1));
    start         = arb_ok && (!stream || last_beat);
    winner        = last_q;
    cand          = '0;
    win_found     = 1'b0;
    for (int i = 1; i <= NUM_ANT; i++) begin
      cand = AW'((int'(last_q) + i) % NUM_ANT);
      if (!win_found && req_i[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    last_d  = last_q;
    push    = 1'b0;
    case (state_q)
      IDLE: grant_d = '0;
      STREAM: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = STREAM;
      grant_d = NUM_ANT'(1) << winner;
      last_d  = winner;
      beat_d  = '0;
      push    = 1'b1;
    end
  end

  // Stage p0 -> p1: granted pair (or zeros on underrun) toward the FFT.
  always_comb begin
    dat0_d = '0;
    dat1_d = '0;
    if (stream && in_valid_i[last_q]) begin
      dat0_d = in_data_0_i[last_q];
      dat1_d = in_data_1_i[last_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      beat_q    <= '0;
      last_q    <= AW'(NUM_ANT - 1);
      vld_p1_q  <= 1'b0;
      dat0_p1_q <= '0;
      dat1_p1_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      under_q   <= 1'b0;
      tagerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      vld_p1_q  <= stream;
      dat0_p1_q <= dat0_d;
      dat1_p1_q <= dat1_d;
      cnt_q     <= cnt_q + IW'(push) - IW'(pop);
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      under_q   <= under_q | (stream & ~in_valid_i[last_q]);
      tagerr_q  <= tagerr_q | (fft_out_valid_i & (cnt_q == '0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= winner;
  end

  assign grant_o         = grant_q;
  assign fft_enable_o    = vld_p1_q;
  assign fft_data_in_0_o = dat0_p1_q;
  assign fft_data_in_1_o = dat1_p1_q;
  assign out_valid_o     = fft_out_valid_i;
  assign out_ant_id_o    = (cnt_q != '0) ? tag_mem_q[rd_ptr_q] : '0;
  assign inflight_o      = cnt_q;
  assign underrun_err_o  = under_q;
  assign tag_err_o       = tagerr_q;

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Time-shares one `fft_N_rad2` engine between `NUM_ANT` antenna sample streams in the MIMO-OFDM receive path. Per-antenna frame requests are granted round-robin, and each granted frame of N/2 sample pairs is muxed onto the FFT's `data_in_0`/`data_in_1` with `enable` asserted. The antenna ID of every in-flight frame is held in a tag FIFO, so each FFT `out_valid` pulse is labelled with its source antenna. Zero-padding and sticky error flags cover requester underrun and orphan FFT outputs.

## Interface
- `N`, 8: FFT size; frame = N/2 beats of two `complex_product_t` samples.
- `NUM_ANT`, 2: number of requesters (≥2).
- `MAX_INFLIGHT`, 2: tag FIFO depth = max frames accepted but not yet output by the FFT.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_ANT: per-antenna frame request; level, held until granted.
- `in_valid` in NUM_ANT: per-antenna sample-pair valid while granted.
- `in_data_0`, `in_data_1` in `complex_product_t` [NUM_ANT]: per-antenna sample pair.
- `grant` out NUM_ANT: one-hot, high for exactly N/2 consecutive cycles per frame.
- `fft_enable` out 1: drives FFT `enable`.
- `fft_data_in_0`, `fft_data_in_1` out `complex_product_t`: drive FFT `data_in_0`/`data_in_1`.
- `fft_out_valid` in 1: FFT `out_valid`.
- `out_valid` out 1: equals `fft_out_valid`.
- `out_ant_id` out $clog2(NUM_ANT): antenna of the frame currently on `fft_out`.
- `inflight` out $clog2(MAX_INFLIGHT+1): tag FIFO occupancy.
- `underrun_err` out 1: sticky; granted requester dropped `in_valid` mid-frame.
- `tag_err` out 1: sticky; `fft_out_valid` seen with tag FIFO empty.

## Operation
- States: IDLE, STREAM. Beat counter `beat` has range 0..N/2-1. Round-robin pointer `last` holds the most recently granted ID.
- Arbitration condition: `|req` and `inflight < MAX_INFLIGHT` (occupancy after any same-cycle pop).
  - Winner = first asserted `req` searching `last+1`, `last+2`, … modulo NUM_ANT.
  - On a win: load `grant` one-hot, push winner ID into the tag FIFO, set `last` = winner, `beat` = 0, go to STREAM.
- IDLE: `grant` = 0. If the arbitration condition holds, take the arbitration action; otherwise stay.
- STREAM: each cycle, capture the granted antenna's data into `fft_data_in_*` and set `fft_enable` = 1 on the next cycle.
  - If the granted `in_valid` = 0, capture zeros instead, keep `fft_enable` = 1, advance `beat`, and set `underrun_err`.
  - `beat` increments each cycle.
  - At `beat` = N/2-1: if the arbitration condition holds, re-arbitrate and go straight to STREAM with the new grant (no bubble). Otherwise go to IDLE.
- `req` of the granted antenna is ignored during its own STREAM. The requester must deassert `req` by the last beat to avoid an immediate re-grant, which round-robin allows only if no other `req` is pending.
- Tag FIFO:
  - Pop on `fft_out_valid` when not empty.
  - Simultaneous push and pop leave `inflight` unchanged. A push is never attempted when full, because arbitration is gated.
  - `fft_out_valid` with the FIFO empty sets `tag_err`, does not pop, and drives `out_ant_id` = 0.
- `out_ant_id` = FIFO head, combinational. `out_valid` = `fft_out_valid`, combinational.
- Reset values: state IDLE, `grant` 0, `fft_enable` 0, `fft_data_in_*` 0, `last` = NUM_ANT-1 (so antenna 0 wins first), FIFO empty, `inflight` 0, both error flags 0.
- Reset asserted mid-frame: all of the above at the next edge. The partial frame is abandoned. FFT pipeline flushing is the FFT's own reset.

## Timing
- Request to grant: `req` sampled high at edge k in IDLE gives `grant` high in cycle k+1.
- Grant is high for cycles k+1 .. k+N/2. The requester drives valid data in those same cycles.
- Data sampled in cycle c appears on `fft_data_in_*` with `fft_enable` = 1 in cycle c+1. `fft_enable` is therefore high for N/2 consecutive cycles, lagging `grant` by 1.
- Back-to-back frames: `grant` moves from one antenna to the other with no gap, and `fft_enable` stays continuously high.
- `inflight` updates one cycle after the push/pop edge.

## Test plan
- **Single frame:** N=8, antenna 1 raises `req`, supplies 4 pairs (1,2),(3,4),(5,6),(7,8) -> `grant` = 2'b10 for 4 cycles; `fft_enable` high 4 cycles, lagging `grant` by 1, carrying the same pairs in order; `inflight` = 1; on `fft_out_valid`, `out_ant_id` = 1 and `inflight` = 0.
- **Contention:** both `req` high from reset -> grants in order 0,1,0,… with no bubble between frames; `fft_enable` continuously high for 8 cycles.
- **Inflight cap:** MAX_INFLIGHT=2, `fft_out_valid` held low, both antennas requesting -> exactly 2 frames granted, then IDLE with `grant` = 0; one `fft_out_valid` pulse -> third frame granted on the next edge.
- **Underrun:** granted antenna drops `in_valid` on beat 2 -> `fft_data_in_*` = 0 for that beat, `fft_enable` stays high, frame still 4 beats long, `underrun_err` = 1 and stays set.
- **Orphan output:** `fft_out_valid` pulse with FIFO empty -> `tag_err` = 1, `out_ant_id` = 0, `inflight` stays 0.
- **Reset mid-frame:** `reset` on beat 1 -> next cycle `grant` = 0, `fft_enable` = 0, `inflight` = 0, errors cleared; the next request starts from antenna 0.
